seq_detect_rx: RTL
==================

# seq_detect_rx

Serial-side receiver that consumes the transmitter's bit stream (`o_seq_bit` plus a per-bit valid strobe and `tx_done`) and detects a fixed PATTERN_W-bit sequence.
- Matches are counted per frame, overlapping matches included.
- The final count is reported with a one-cycle valid strobe when the frame ends.
- It is the downstream consumer of the transmit stage and drives the top-level sequence-count output.

## Interface
Parameters:
- PATTERN_W, 8, pattern length in bits (2..16)
- PATTERN, 8'h48, target sequence; compared MSB-first (first received bit = PATTERN[PATTERN_W-1])
- CNT_W, 10, width of match counter

Ports:
- i_clk  in  1  single clock. All logic is rising-edge.
- i_rst  in  1  synchronous, active-high reset
- i_bit_valid  in  1  i_serial_bit is valid this cycle
- i_serial_bit  in  1  received data bit
- i_tx_done  in  1  one-cycle end-of-frame strobe from transmitter
- o_seq_detected  out  1  one-cycle pulse per match
- o_seq_count  out  CNT_W  match count: running during the frame, final value after it
- o_count_valid  out  1  one-cycle pulse when o_seq_count holds the final frame count
- o_busy  out  1  high while a frame is in progress

## Operation
- Shift register `win[PATTERN_W-1:0]`: on an accepted bit, `win <= {win[PATTERN_W-2:0], i_serial_bit}`.
- Fill counter `fill` counts accepted bits in the frame, from 0 up to PATTERN_W, then holds.
- FSM states: IDLE, FILL, HUNT, REPORT.
  - IDLE: o_busy=0. A valid bit starts a frame in the same cycle: count←0, win←{0..,bit}, fill←1, next state FILL (or HUNT if PATTERN_W reached).
  - FILL: shift on each valid bit. Go to HUNT in the same cycle that fill reaches PATTERN_W, and evaluate the match on that updated window.
  - HUNT: on each valid bit, compare the updated window against PATTERN.
    - On match: pulse o_seq_detected; count ← count+1, saturating at 2^CNT_W−1.
    - Overlap is inherent; the window is never cleared on a match.
  - FILL or HUNT with i_tx_done=1: next state REPORT. A valid bit in the same cycle is processed first and can count.
  - REPORT: one cycle. o_count_valid=1, then IDLE. win and fill are cleared; o_seq_count holds its value.
- i_tx_done in IDLE: ignored, no report.
- Frames shorter than PATTERN_W bits report count 0.
- i_bit_valid in REPORT: the bit is dropped. The transmitter guarantees at least one idle cycle after tx_done.
- i_bit_valid=0: window, fill and count unchanged; gaps between bits are arbitrary.

## Timing
- Reset values: all outputs 0; state IDLE; win, fill and count all 0.
- Reset mid-frame takes priority over everything: the next cycle is IDLE with all outputs 0 and no report.
- Detection latency: o_seq_detected and the incremented o_seq_count appear in the cycle after the completing bit is sampled (registered outputs).
- o_count_valid rises the cycle after the i_tx_done sample. o_seq_count is stable in that cycle and stays so until the next frame's first bit.
- Back-to-back valid bits (every cycle) are supported at full rate.
- Saturation: at count = 2^CNT_W−1, further matches still pulse o_seq_detected, but the count does not wrap.

## Structure
- Shared package (e.g. `hbd_pkg`): FSM state enum, default PATTERN/PATTERN_W/CNT_W constants shared with generator and transmitter.
- One natural sub-module, `seq_match_window`: the shift register plus fill counter plus comparator, producing `match` and `full`.
- The FSM and counter stay in `seq_detect_rx`.
- Target 150–250 lines RTL total.

## Test plan
- Reset then stream 0100_1000 (8'h48) contiguous, then tx_done:
  - o_seq_detected pulses once, one cycle after the 8th bit.
  - o_count_valid pulses with o_seq_count=1.
- Overlap, PATTERN_W=4, PATTERN=4'b1010, stream 1010101 then tx_done:
  - 2 matches (bits 4 and 6).
  - Reported count=2.
- Pattern bits spread with random i_bit_valid gaps (1–5 idle cycles): same result as the contiguous case (count=1). No pulses during gaps.
- Last bit completing a match coincides with i_tx_done: the match counts; report count=1 the next cycle.
- Reset boundaries:
  - Frame of 3 bits then tx_done: report count=0.
  - i_tx_done while IDLE: no o_count_valid.
  - i_rst asserted mid-frame after 1 match: no report; outputs 0; the next frame starts from count 0.
- Saturation, CNT_W=2, PATTERN_W=2, PATTERN=2'b11, stream of eight 1s:
  - 7 o_seq_detected pulses.
  - Count sticks at 3; report value 3.

Source files
------------

// File: rtl/seq_detect_rx_pkg.sv
// rtl/seq_detect_rx_pkg.sv - shared types and default constants for the sequence detector
//
// Purpose: FSM state encoding and the default PATTERN/PATTERN_W/CNT_W values
//          shared by the generator, transmitter and receiver blocks.
// Ports:   none (package).

package seq_detect_rx_pkg;

    localparam int          DEF_PATTERN_W = 8;
    localparam logic [15:0] DEF_PATTERN   = 16'h0048;
    localparam int          DEF_CNT_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_HUNT   = 2'd2,
        ST_REPORT = 2'd3
    } rx_state_e;

    // Width needed to hold a fill count from 0 up to and including pattern_w.
    function automatic int fill_width(input int pattern_w);
        return $clog2(pattern_w + 1);
    endfunction

endpackage

// File: rtl/seq_detect_rx_if.sv
// rtl/seq_detect_rx_if.sv - serial bit stream in / match results out bundle
//
// Purpose: groups the receiver's bit-stream inputs and result outputs.
// Signals:
//   i_bit_valid    master->slave  serial bit valid this cycle
//   i_serial_bit   master->slave  received data bit
//   i_tx_done      master->slave  one-cycle end-of-frame strobe
//   o_seq_detected slave->master  one-cycle pulse per match
//   o_seq_count    slave->master  running / final match count (CNT_W bits)
//   o_count_valid  slave->master  one-cycle pulse with the final frame count
//   o_busy         slave->master  frame in progress
// Modports: master (transmitter / bench side), slave (receiver side).

interface seq_detect_rx_if
    import seq_detect_rx_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             i_bit_valid;
    logic             i_serial_bit;
    logic             i_tx_done;
    logic             o_seq_detected;
    logic [CNT_W-1:0] o_seq_count;
    logic             o_count_valid;
    logic             o_busy;

    modport master (
        output i_bit_valid,
        output i_serial_bit,
        output i_tx_done,
        input  o_seq_detected,
        input  o_seq_count,
        input  o_count_valid,
        input  o_busy
    );

    modport slave (
        input  i_bit_valid,
        input  i_serial_bit,
        input  i_tx_done,
        output o_seq_detected,
        output o_seq_count,
        output o_count_valid,
        output o_busy
    );

endinterface

// File: rtl/seq_match_window.sv
// rtl/seq_match_window.sv - shift window, fill counter and pattern comparator
//
// Purpose: keeps the last PATTERN_W accepted bits and how many bits of the
//          frame have been seen (saturating at PATTERN_W). o_match/o_full are
//          evaluated on the window as it will be after this cycle's bit, so
//          the controller can register the result on the same edge.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_clear       drop window and fill (end of frame)
//   i_start       first bit of a frame: window <= {0.., i_bit}, fill <= 1
//   i_shift       further bit of a frame: shift i_bit in, fill++ (saturating)
//   i_bit         data bit
//   o_match       a bit is being accepted and the updated window equals PATTERN
//   o_full        updated fill count has reached PATTERN_W

module seq_match_window
    import seq_detect_rx_pkg::*;
#(
    parameter int                   PATTERN_W = DEF_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN   = DEF_PATTERN[PATTERN_W-1:0]
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_start,
    input  logic i_shift,
    input  logic i_bit,
    output logic o_match,
    output logic o_full
);

    localparam int              FILL_W   = fill_width(PATTERN_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W);

    logic [PATTERN_W-1:0] win_q;
    logic [PATTERN_W-1:0] win_d;
    logic [FILL_W-1:0]    fill_q;
    logic [FILL_W-1:0]    fill_d;

    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        if (i_clear) begin
            win_d  = '0;
            fill_d = '0;
        end else if (i_start) begin
            win_d  = {{(PATTERN_W-1){1'b0}}, i_bit};
            fill_d = FILL_W'(1);
        end else if (i_shift) begin
            win_d = {win_q[PATTERN_W-2:0], i_bit};
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // Bits left over from before the frame start are never compared: a match
    // needs PATTERN_W bits of this frame in the window.
    assign o_full  = (fill_d == FILL_MAX);
    assign o_match = (i_start || i_shift) && o_full && (win_d == PATTERN);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            win_q  <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_rx.sv
// rtl/seq_detect_rx.sv - serial sequence detector with per-frame match count
//
// Purpose: consumes the transmitter bit stream, counts (overlapping) matches of
//          PATTERN per frame and reports the final count when the frame ends.
// Ports:
//   i_clk   single rising-edge clock
//   i_rst   synchronous active-high reset
//   bus     seq_detect_rx_if.slave: i_bit_valid, i_serial_bit, i_tx_done in;
//           o_seq_detected, o_seq_count, o_count_valid, o_busy out (all registered)

module seq_detect_rx
    import seq_detect_rx_pkg::*;
#(
    parameter int                   PATTERN_W = DEF_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN   = DEF_PATTERN[PATTERN_W-1:0],
    parameter int                   CNT_W     = DEF_CNT_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    seq_detect_rx_if.slave     bus
);

    rx_state_e        state_q;
    logic [CNT_W-1:0] count_q;
    logic             detected_q;
    logic             count_valid_q;
    logic             busy_q;

    logic             in_frame;
    logic             win_start;
    logic             win_shift;
    logic             win_clear;
    logic             win_match;
    logic             win_full;
    logic [CNT_W-1:0] count_inc;

    assign in_frame  = (state_q == ST_FILL) || (state_q == ST_HUNT);
    assign win_start = bus.i_bit_valid && (state_q == ST_IDLE);
    assign win_shift = bus.i_bit_valid && in_frame;
    // A bit arriving during REPORT is dropped; the clear wins.
    assign win_clear = (state_q == ST_REPORT);

    assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    seq_match_window #(
        .PATTERN_W (PATTERN_W),
        .PATTERN   (PATTERN)
    ) u_window (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (win_clear),
        .i_start (win_start),
        .i_shift (win_shift),
        .i_bit   (bus.i_serial_bit),
        .o_match (win_match),
        .o_full  (win_full)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            detected_q    <= 1'b0;
            count_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            detected_q    <= 1'b0;
            count_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A lone tx_done with no bit is ignored. A first bit that
                    // arrives together with tx_done forms a one-bit frame.
                    if (bus.i_bit_valid) begin
                        busy_q     <= 1'b1;
                        detected_q <= win_match;
                        count_q    <= win_match ? CNT_W'(1) : '0;
                        if (bus.i_tx_done) begin
                            count_valid_q <= 1'b1;
                            state_q       <= ST_REPORT;
                        end else begin
                            state_q <= win_full ? ST_HUNT : ST_FILL;
                        end
                    end
                end
                ST_FILL, ST_HUNT: begin
                    if (win_shift && win_match) begin
                        detected_q <= 1'b1;
                        count_q    <= count_inc;
                    end
                    if (bus.i_tx_done) begin
                        count_valid_q <= 1'b1;
                        state_q       <= ST_REPORT;
                    end else begin
                        state_q <= win_full ? ST_HUNT : ST_FILL;
                    end
                end
                ST_REPORT: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_seq_detected = detected_q;
    assign bus.o_seq_count    = count_q;
    assign bus.o_count_valid  = count_valid_q;
    assign bus.o_busy         = busy_q;

endmodule
